// File: rtl/pwm_led_pkg.sv
// Shared register map, CTRL bit positions, CH field ranges and duty width for the LED PWM block.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pwm_led_pkg;

  localparam int DUTY_W      = 8;
  localparam int BLINK_DIV_W = 16;

  // Byte offsets of the register map
  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_PERIOD  = 8'h04;
  localparam logic [7:0] ADDR_BLINK   = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h0C;
  localparam logic [7:0] ADDR_CH_BASE = 8'h40;

  // Word indices (byte address bits [7:2])
  localparam logic [5:0] WORD_CTRL    = ADDR_CTRL[7:2];
  localparam logic [5:0] WORD_PERIOD  = ADDR_PERIOD[7:2];
  localparam logic [5:0] WORD_BLINK   = ADDR_BLINK[7:2];
  localparam logic [5:0] WORD_STATUS  = ADDR_STATUS[7:2];
  localparam logic [5:0] WORD_CH_BASE = ADDR_CH_BASE[7:2];

  // CTRL bit positions
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_BLINK_BIT   = 1;
  localparam int CTRL_BREATHE_BIT = 2;

  // CH_i field ranges
  localparam int CH_DUTY_A_LSB = 0;
  localparam int CH_DUTY_A_MSB = 7;
  localparam int CH_DUTY_B_LSB = 8;
  localparam int CH_DUTY_B_MSB = 15;

  typedef enum logic {
    ST_A = 1'b0,
    ST_B = 1'b1
  } blink_state_t;

endpackage

// File: rtl/pwm_led_channel.sv
// One PWM channel: brightness-scaled duty, period threshold and counter compare.
// Latency: combinational; the top registers the result.
// Backpressure: none.
module pwm_led_channel
  import pwm_led_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic [DUTY_W-1:0] duty_a,
  input  logic [DUTY_W-1:0] duty_b,
  input  logic              sel_b,
  input  logic [DUTY_W-1:0] bright,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  cnt,
  output logic              hit
);

  logic [DUTY_W-1:0]       duty;
  logic [2*DUTY_W-1:0]     scaled;
  logic [DUTY_W-1:0]       duty_eff;
  logic [CNT_W+DUTY_W-1:0] thr_full;
  logic [CNT_W-1:0]        thr;
  logic                    unused_lsbs;

  // Scale duty by brightness, widen before multiplying by PERIOD so no bits are lost before the >>8.
  always_comb begin
    duty     = sel_b ? duty_b : duty_a;
    scaled   = (2*DUTY_W)'(duty) * ((2*DUTY_W)'(bright) + (2*DUTY_W)'(1));
    duty_eff = scaled[2*DUTY_W-1:DUTY_W];
    thr_full = (CNT_W+DUTY_W)'(duty_eff) * (CNT_W+DUTY_W)'(period);
    thr      = thr_full[CNT_W+DUTY_W-1:DUTY_W];
    hit      = (cnt < thr);
    // Full scale must be solid on and zero must be solid off regardless of rounding
    if (duty_eff == '1) begin
      hit = 1'b1;
    end else if (duty_eff == '0) begin
      hit = 1'b0;
    end
  end

  assign unused_lsbs = ^{scaled[DUTY_W-1:0], thr_full[DUTY_W-1:0]};

endmodule

// File: rtl/multi_pwm_led.sv
// Multi-channel LED PWM with register bus, period-aligned shadow registers, blink and optional breathing (MULTI_PWM_LED_BREATHE_EN).
// Latency: bus_read_data one cycle after bus_read_en; pwm_out one cycle behind the period counter.
// Backpressure: none; bus strobes are accepted every cycle and never stalled.
module multi_pwm_led
  import pwm_led_pkg::*;
#(
  parameter int NUM_CH         = 3,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 1000000
) (
  input  logic              pclk,
  input  logic              nreset,
  input  logic              bus_write_en,
  input  logic              bus_read_en,
  input  logic [7:0]        bus_addr,
  input  logic [31:0]       bus_write_data,
  output logic [31:0]       bus_read_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  localparam logic [CNT_W-1:0]       PERIOD_RST = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0]       PERIOD_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
  localparam logic [BLINK_DIV_W-1:0] BLINK_ONE  = BLINK_DIV_W'(1);

  logic [5:0]             word;
  logic [2:0]             ch_idx;
  logic                   ch_hit;
  logic                   wr_ctrl, wr_period, wr_blink, wr_ch;
  logic [CNT_W-1:0]       wr_period_val;
  logic                   ctrl_en, ctrl_blink, breathe_bit;
  logic                   en_nxt, start, wrap, commit;
  logic [CNT_W-1:0]       cnt, period_pend, period_act;
  logic [BLINK_DIV_W-1:0] blink_pend, blink_act, blink_cnt, blink_lim;
  logic [DUTY_W-1:0]      duty_a_pend [NUM_CH];
  logic [DUTY_W-1:0]      duty_b_pend [NUM_CH];
  logic [DUTY_W-1:0]      duty_a_act  [NUM_CH];
  logic [DUTY_W-1:0]      duty_b_act  [NUM_CH];
  blink_state_t           state;
  logic [DUTY_W-1:0]      bright;
  logic [NUM_CH-1:0]      cmp;
  logic [31:0]            rd_val;
  logic                   unused_bits;

  assign word          = bus_addr[7:2];
  assign ch_idx        = word[2:0];
  assign ch_hit        = (word[5:3] == WORD_CH_BASE[5:3]) && (int'(ch_idx) < NUM_CH);
  assign wr_ctrl       = bus_write_en && (word == WORD_CTRL);
  assign wr_period     = bus_write_en && (word == WORD_PERIOD);
  assign wr_blink      = bus_write_en && (word == WORD_BLINK);
  assign wr_ch         = bus_write_en && ch_hit;
  assign wr_period_val = bus_write_data[CNT_W-1:0];
  assign unused_bits   = ^{bus_addr[1:0], bus_write_data};

  // Enable as it will be after this cycle; lets a disable gate pwm_out on the very next edge
  assign en_nxt      = wr_ctrl ? bus_write_data[CTRL_EN_BIT] : ctrl_en;
  assign start       = wr_ctrl && bus_write_data[CTRL_EN_BIT] && !ctrl_en;
  assign wrap        = ctrl_en && (cnt == period_act - CNT_ONE);
  assign commit      = wrap || start;
  assign period_tick = wrap;
  assign blink_lim   = (blink_act == '0) ? BLINK_ONE : blink_act;

  // CTRL enable and blink bits
  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      ctrl_en    <= 1'b0;
      ctrl_blink <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en    <= bus_write_data[CTRL_EN_BIT];
      ctrl_blink <= bus_write_data[CTRL_BLINK_BIT];
    end
  end

  // Period counter: held at 0 while disabled, so enabling always starts a fresh period
  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (!ctrl_en || !en_nxt || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Pending copies take bus writes; active copies load only at a period boundary or on enable
  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      period_pend <= PERIOD_RST;
      period_act  <= PERIOD_RST;
      blink_pend  <= '0;
      blink_act   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_a_pend[i] <= '0;
        duty_b_pend[i] <= '0;
        duty_a_act[i]  <= '0;
        duty_b_act[i]  <= '0;
      end
    end else begin
      if (wr_period) begin
        period_pend <= (wr_period_val < PERIOD_MIN) ? PERIOD_MIN : wr_period_val;
      end
      if (wr_blink) begin
        blink_pend <= bus_write_data[BLINK_DIV_W-1:0];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ch && (int'(ch_idx) == i)) begin
          duty_a_pend[i] <= bus_write_data[CH_DUTY_A_MSB:CH_DUTY_A_LSB];
          duty_b_pend[i] <= bus_write_data[CH_DUTY_B_MSB:CH_DUTY_B_LSB];
        end
      end
      if (commit) begin
        period_act <= period_pend;
        blink_act  <= blink_pend;
        for (int i = 0; i < NUM_CH; i++) begin
          duty_a_act[i] <= duty_a_pend[i];
          duty_b_act[i] <= duty_b_pend[i];
        end
      end
    end
  end

  // Blink: toggle A/B after BLINK_DIV completed periods; parked at A with count 0 when off
  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      state     <= ST_A;
      blink_cnt <= '0;
    end else if (!ctrl_blink) begin
      state     <= ST_A;
      blink_cnt <= '0;
    end else if (wrap) begin
      if (blink_cnt + BLINK_ONE >= blink_lim) begin
        state     <= (state == ST_A) ? ST_B : ST_A;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BLINK_ONE;
      end
    end
  end

`ifdef MULTI_PWM_LED_BREATHE_EN
  logic              ctrl_breathe;
  logic [DUTY_W-1:0] bright_r;
  logic              dir_down;

  // CTRL breathe bit
  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      ctrl_breathe <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_breathe <= bus_write_data[CTRL_BREATHE_BIT];
    end
  end

  // Triangle envelope, one step per period, turning around at 0 and 255 without dwelling
  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      bright_r <= '1;
      dir_down <= 1'b1;
    end else if (!ctrl_breathe) begin
      bright_r <= '1;
      dir_down <= 1'b1;
    end else if (wrap) begin
      if (dir_down) begin
        if (bright_r == '0) begin
          bright_r <= DUTY_W'(1);
          dir_down <= 1'b0;
        end else begin
          bright_r <= bright_r - DUTY_W'(1);
        end
      end else begin
        if (bright_r == '1) begin
          bright_r <= bright_r - DUTY_W'(1);
          dir_down <= 1'b1;
        end else begin
          bright_r <= bright_r + DUTY_W'(1);
        end
      end
    end
  end

  assign bright      = bright_r;
  assign breathe_bit = ctrl_breathe;
`else
  assign bright      = '1;
  assign breathe_bit = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_led_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .duty_a (duty_a_act[i]),
      .duty_b (duty_b_act[i]),
      .sel_b  (state == ST_B),
      .bright (bright),
      .period (period_act),
      .cnt    (cnt),
      .hit    (cmp[i])
    );
  end

  // Output register: one cycle behind the counter, forced low whenever disabled or being disabled
  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      pwm_out <= '0;
    end else if (ctrl_en && en_nxt) begin
      pwm_out <= cmp;
    end else begin
      pwm_out <= '0;
    end
  end

  // Read mux over current values, so a same-cycle write is not visible yet
  always_comb begin
    rd_val = '0;
    case (word)
      WORD_CTRL: begin
        rd_val[CTRL_EN_BIT]      = ctrl_en;
        rd_val[CTRL_BLINK_BIT]   = ctrl_blink;
        rd_val[CTRL_BREATHE_BIT] = breathe_bit;
      end
      WORD_PERIOD: rd_val = 32'(period_pend);
      WORD_BLINK:  rd_val[BLINK_DIV_W-1:0] = blink_pend;
      WORD_STATUS: begin
        rd_val[0]    = (state == ST_B);
        rd_val[15:8] = bright;
      end
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_hit && (int'(ch_idx) == i)) begin
            rd_val[CH_DUTY_A_MSB:CH_DUTY_A_LSB] = duty_a_pend[i];
            rd_val[CH_DUTY_B_MSB:CH_DUTY_B_LSB] = duty_b_pend[i];
          end
        end
      end
    endcase
  end

  // Registered read data, holds between reads
  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      bus_read_data <= '0;
    end else if (bus_read_en) begin
      bus_read_data <= rd_val;
    end
  end

endmodule

// File: tb/tb_multi_pwm_led.sv
// Directed bench for multi_pwm_led: register map, PWM shape, shadow commit, blink, enable, breathe, reset.
// Latency: expectations encode one-cycle read data and one-cycle pwm_out lag.
// Backpressure: n/a.
module tb_multi_pwm_led;

  logic        pclk;
  logic        nreset;
  logic        bus_write_en;
  logic        bus_read_en;
  logic [7:0]  bus_addr;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic [2:0]  pwm_out;
  logic        period_tick;

  int errors = 0;
  int checks = 0;

  logic [19:0] pat20, tk20;
  logic [15:0] pat16;
  logic [39:0] pat40;
  logic [31:0] rd;
  int          n;
  int          hi_cnt;

  multi_pwm_led #(
    .NUM_CH         (3),
    .CNT_W          (32),
    .DEFAULT_PERIOD (1000000)
  ) dut (
    .pclk           (pclk),
    .nreset         (nreset),
    .bus_write_en   (bus_write_en),
    .bus_read_en    (bus_read_en),
    .bus_addr       (bus_addr),
    .bus_write_data (bus_write_data),
    .bus_read_data  (bus_read_data),
    .pwm_out        (pwm_out),
    .period_tick    (period_tick)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge pclk);
    bus_write_en   = 1'b1;
    bus_addr       = a;
    bus_write_data = d;
    @(negedge pclk);
    bus_write_en   = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge pclk);
    bus_read_en = 1'b1;
    bus_addr    = a;
    @(negedge pclk);
    bus_read_en = 1'b0;
    d = bus_read_data;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check_val(tag, 64'(d), 64'(exp));
  endtask

  task automatic wait_tick(input string tag);
    int k = 0;
    do begin
      @(negedge pclk);
      k++;
    end while (!period_tick && k < 100);
    check_val(tag, 64'(period_tick), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0;
    bus_write_en = 1'b0;
    bus_read_en = 1'b0;
    bus_addr = '0;
    bus_write_data = '0;
    repeat (3) @(negedge pclk);
    check_val("rst_pwm", 64'(pwm_out), 64'd0);
    check_val("rst_tick", 64'(period_tick), 64'd0);
    check_val("rst_rdata", 64'(bus_read_data), 64'd0);
    nreset = 1'b1;

    // Register map and reset values
    rd_chk("period_rst", 8'h04, 32'd1000000);
    rd_chk("status_rst", 8'h0C, 32'h0000FF00);
    rd_chk("ctrl_rst", 8'h00, 32'h0);
    bus_wr(8'h04, 32'd1);
    rd_chk("period_min", 8'h04, 32'd2);
    bus_wr(8'h04, 32'd10);
    rd_chk("period_10", 8'h04, 32'd10);
    bus_wr(8'h40, 32'h0000_0080);
    rd_chk("ch0_rd", 8'h40, 32'h0000_0080);
    bus_wr(8'h08, 32'h0001_2345);
    rd_chk("blink_16b", 8'h08, 32'h0000_2345);
    rd_chk("ch3_unmapped", 8'h4C, 32'h0);
    rd_chk("unmapped", 8'h20, 32'h0);
    bus_wr(8'h0C, 32'hFFFF_FFFF);
    rd_chk("status_ro", 8'h0C, 32'h0000FF00);

    // Simultaneous read and write returns the old value
    @(negedge pclk);
    bus_write_en = 1'b1;
    bus_read_en = 1'b1;
    bus_addr = 8'h44;
    bus_write_data = 32'h0000_1234;
    @(negedge pclk);
    bus_write_en = 1'b0;
    bus_read_en = 1'b0;
    check_val("rw_same_cycle", 64'(bus_read_data), 64'h0);
    rd_chk("rw_after", 8'h44, 32'h0000_1234);

    // 50% duty at PERIOD=10
    bus_wr(8'h00, 32'h1);
    for (int k = 0; k < 20; k++) begin
      @(negedge pclk);
      pat20[k] = pwm_out[0];
      tk20[k] = period_tick;
    end
    check_val("pwm_50pct", 64'(pat20), 64'h07C1F);
    check_val("tick_every10", 64'(tk20), 64'h40100);

    // Mid-period duty change only takes effect after the wrap
    wait_tick("sync_tick");
    repeat (3) @(negedge pclk);
    bus_wr(8'h40, 32'h0000_00FF);
    for (int k = 0; k < 16; k++) begin
      @(negedge pclk);
      pat16[k] = pwm_out[0];
    end
    check_val("duty_commit", 64'(pat16), 64'hFFC1);

    // Disable while high, then re-enable from counter 0
    check_val("pre_disable_hi", 64'(pwm_out[0]), 64'd1);
    bus_wr(8'h00, 32'h0);
    check_val("disable_next", 64'(pwm_out), 64'd0);
    hi_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge pclk);
      hi_cnt += int'(pwm_out[0]) + int'(period_tick);
    end
    check_val("disabled_quiet", 64'(hi_cnt), 64'd0);
    bus_wr(8'h40, 32'h0000_FF00);
    rd_chk("wr_while_off", 8'h40, 32'h0000_FF00);
    bus_wr(8'h08, 32'd2);
    bus_wr(8'h00, 32'h1);
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!period_tick && n < 50);
    check_val("restart_at0", 64'(n), 64'd9);
    bus_wr(8'h00, 32'h0);

    // Blink: duty_A=0, duty_B=255, BLINK_DIV=2
    bus_wr(8'h00, 32'h3);
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      pat40[k] = pwm_out[0];
    end
    check_val("blink_pattern", 64'(pat40), 64'hFF_FFF0_0000);
    rd_chk("status_A", 8'h0C, 32'h0000FF00);
    repeat (20) @(negedge pclk);
    rd_chk("status_B", 8'h0C, 32'h0000FF01);

    // Breathing envelope at PERIOD=4, full duty
    bus_wr(8'h00, 32'h0);
    bus_wr(8'h40, 32'h0000_00FF);
    bus_wr(8'h04, 32'd4);
`ifdef MULTI_PWM_LED_BREATHE_EN
    bus_wr(8'h00, 32'h5);
    wait_tick("breathe_tick1");
    rd_chk("bright_254", 8'h0C, 32'h0000FE00);
    for (int k = 0; k < 254; k++) begin
      wait_tick("breathe_tick");
    end
    rd_chk("bright_0", 8'h0C, 32'h0000_0000);
    wait_tick("breathe_turn");
    rd_chk("bright_rise", 8'h0C, 32'h0000_0100);
    rd_chk("ctrl_breathe", 8'h00, 32'h5);
`else
    bus_wr(8'h00, 32'h5);
    rd_chk("ctrl_no_breathe", 8'h00, 32'h1);
    wait_tick("const_tick1");
    repeat (3) wait_tick("const_tick");
    rd_chk("bright_const", 8'h0C, 32'h0000FF00);
`endif

    // Asynchronous reset mid-period discards pending values
    bus_wr(8'h00, 32'h1);
    repeat (2) @(negedge pclk);
    check_val("pre_rst_hi", 64'(pwm_out[0]), 64'd1);
    bus_wr(8'h40, 32'h0000_1111);
    rd_chk("pre_rst_rd", 8'h00, 32'h1);
    #2 nreset = 1'b0;
    #1;
    check_val("arst_pwm", 64'(pwm_out), 64'd0);
    check_val("arst_tick", 64'(period_tick), 64'd0);
    check_val("arst_rdata", 64'(bus_read_data), 64'd0);
    repeat (2) @(negedge pclk);
    nreset = 1'b1;
    rd_chk("period_after_rst", 8'h04, 32'd1000000);
    rd_chk("ch0_discarded", 8'h40, 32'h0);
    rd_chk("ctrl_after_rst", 8'h00, 32'h0);
    hi_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge pclk);
      hi_cnt += int'(pwm_out != 3'b000) + int'(period_tick);
    end
    check_val("idle_after_rst", 64'(hi_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
